// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side master.
package fifo_reader_pkg;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int SKID_DEPTH     = 2;

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_FLUSH} rd_state_e;
endpackage

// File: rtl/fifo_reader_if.sv
// Valid/ready output stream presented by the FIFO reader.
interface fifo_reader_if #(
  parameter int W = 16
);
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_reader_skid.sv
// 2-entry FIFO-ordered buffer; ent0 is always the head so head data comes straight off a flop.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head,
  output logic         vld
);
  logic [W-1:0] ent1;
  logic         pop_ok;
  logic         push_ok;
  logic [1:0]   occ_nxt;

  assign pop_ok  = pop && (occ != 2'd0);
  assign push_ok = push && ((occ != 2'(SKID_DEPTH)) || pop_ok);

  always_comb begin
    occ_nxt = occ;
    case ({push_ok, pop_ok})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
      vld  <= 1'b0;
    end else begin
      occ <= occ_nxt;
      vld <= (occ_nxt != 2'd0);
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             ent1 <= din;
        end
        2'b01: head <= ent1;
        2'b11: begin
          // simultaneous push/pop: with one entry the new word becomes head directly
          if (occ == 2'd1) head <= din;
          else begin
            head <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO and re-presents its words as a valid/ready stream.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_reader_if.master         m,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  underflow_err
);
  rd_state_e             state;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  pop;
  logic [2:0]            pend;
  logic [FIFO_WIDTH-1:0] head;
  logic                  vld;

  assign pop  = vld && m.m_ready;
  // occupancy after this edge if no new read is issued; pop implies occ >= 1
  assign pend = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == RD_RUN) && !fifo_empty && (pend < 3'(SKID_DEPTH));

  assign m.m_valid = vld;
  assign m.m_data  = head;

  fifo_reader_skid #(.W(FIFO_WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_data_out),
    .pop  (pop),
    .occ  (occ),
    .head (head),
    .vld  (vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RD_IDLE;
      busy          <= 1'b0;
      inflight      <= 1'b0;
      beat_count    <= '0;
      underflow_err <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop)            beat_count    <= beat_count + CNT_WIDTH'(1);
      if (fifo_underflow) underflow_err <= 1'b1;
      case (state)
        RD_IDLE: if (enable) begin
          state <= RD_RUN;
          busy  <= 1'b1;
        end
        RD_RUN: if (!enable) state <= RD_FLUSH;
        RD_FLUSH: begin
          if (enable) state <= RD_RUN;
          else if (!inflight && (occ == 2'd0)) begin
            state <= RD_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO model plus a scoreboard of words popped but not yet delivered.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty = 1'b1;
  logic        fifo_underflow;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_rd_en;
  logic        busy;
  logic [15:0] beat_count;
  logic        underflow_err;

  fifo_reader_if #(.W(16)) bus ();

  fifo_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m              (bus),
    .busy           (busy),
    .beat_count     (beat_count),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  logic [15:0] q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] nxt_data = '0;
  logic        nxt_vld = 1'b0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_cyc = 0;
  int          vrise_cyc = 0;
  int          tb_beats = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (nxt_vld) fifo_data_out <= nxt_data;
    fifo_empty <= (q.size() == 0);
  end

  always @(negedge clk) begin
    logic [15:0] w;
    if (rst) begin
      exp_q.delete();
      tb_beats   = 0;
      stall_prev = 1'b0;
      prev_valid = 1'b0;
      nxt_vld    = 1'b0;
    end else begin
      if (stall_prev) check("hold_while_stalled", bus.m_data, stall_data);
      if (bus.m_valid && !prev_valid) vrise_cyc = cyc;
      nxt_vld = 1'b0;
      if (fifo_rd_en) begin
        check("rd_en_while_empty", fifo_empty, 0);
        rd_cyc = cyc;
        rd_cnt++;
        if (q.size() > 0) begin
          w = q.pop_front();
          exp_q.push_back(w);
          nxt_data = w;
          nxt_vld  = 1'b1;
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
        else begin
          w = exp_q.pop_front();
          check("beat_data", bus.m_data, w);
        end
        got_q.push_back(bus.m_data);
        tb_beats++;
      end
      check("outstanding_le2", exp_q.size() <= 2, 1);
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      prev_valid = bus.m_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) q.push_back(base + 16'(i));
    tick();
    tick();
  endtask

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      if (!busy) break;
      tick();
    end
    check("reach_idle", busy, 0);
  endtask

  task automatic drain(input int bound);
    int n;
    m_ready_set(1'b1);
    enable = 1'b1;
    n = 0;
    while ((q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", n < bound, 1);
    enable = 1'b0;
    wait_idle(20);
  endtask

  task automatic m_ready_set(input logic v);
    bus.m_ready = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"}, bus.m_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_beat_count"}, beat_count, 0);
    check({tag, "_underflow_err"}, underflow_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, b0, g0, n, remain_n;
    logic [15:0] remain_first;
    rst = 1'b1;
    enable = 1'b0;
    fifo_underflow = 1'b0;
    m_ready_set(1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // single word
    q.push_back(16'hA5A5);
    tick();
    tick();
    rd0 = rd_cnt;
    m_ready_set(1'b1);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("single_rd_pulses", rd_cnt - rd0, 1);
    check("single_latency", vrise_cyc - rd_cyc, 2);
    check("single_data", got_q[got_q.size()-1], 16'hA5A5);
    check("single_beat_count", beat_count, 1);
    check("single_busy_run", busy, 1);
    enable = 1'b0;
    wait_idle(20);

    // full burst, contiguous beats in order
    load_seq(8, 16'h0001);
    b0 = tb_beats;
    enable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("burst_start", bus.m_valid, 1);
    for (int i = 0; i < 8; i++) begin
      check("burst_contig", bus.m_valid && bus.m_ready, 1);
      check("burst_order", bus.m_data, 16'(i + 1));
      @(negedge clk);
    end
    tick();
    enable = 1'b0;
    wait_idle(20);
    check("burst_beats", tb_beats - b0, 8);
    check("burst_beat_count", beat_count, 9);

    // backpressure with ready pattern 1,0,0
    load_seq(8, 16'h0001);
    b0 = tb_beats;
    g0 = got_q.size();
    enable = 1'b1;
    n = 0;
    while (tb_beats - b0 < 8 && n < 80) begin
      m_ready_set((n % 3) == 0);
      tick();
      n++;
    end
    m_ready_set(1'b1);
    enable = 1'b0;
    wait_idle(20);
    check("bp_beats", tb_beats - b0, 8);
    for (int i = 0; i < 8; i++) check("bp_order", got_q[g0 + i], 16'(i + 1));

    // enable drop during the 3rd read
    load_seq(8, 16'h0001);
    rd0 = rd_cnt;
    b0 = tb_beats;
    enable = 1'b1;
    n = 0;
    while (rd_cnt - rd0 < 2 && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    wait_idle(20);
    check("drop_reads", rd_cnt - rd0, 3);
    check("drop_beats", tb_beats - b0, 3);
    check("drop_fifo_left", q.size(), 5);

    // reset mid-burst, then restart
    for (int i = 0; i < 8; i++) q.push_back(16'h0009 + 16'(i));
    tick();
    tick();
    b0 = tb_beats;
    enable = 1'b1;
    n = 0;
    while (tb_beats - b0 < 2 && n < 20) begin
      tick();
      n++;
    end
    @(posedge clk);
    #2;
    fifo_underflow = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    enable = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_beats", beat_count, 0);
    remain_n = q.size();
    remain_first = q[0];
    g0 = got_q.size();
    drain(100);
    check("restart_count", beat_count, 16'(remain_n));
    check("restart_first", got_q[g0], remain_first);
    check("restart_last", got_q[got_q.size()-1], 16'h0010);

    // sticky underflow
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    check("uflow_set", underflow_err, 1);
    for (int i = 0; i < 4; i++) tick();
    check("uflow_sticky", underflow_err, 1);
    rst = 1'b1;
    #1;
    check("uflow_cleared", underflow_err, 0);
    tick();
    rst = 1'b0;
    tick();

    // randomized ready/enable
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) q.push_back(16'($urandom));
      tick();
      tick();
      for (int c = 0; c < 150; c++) begin
        m_ready_set(1'($urandom_range(0, 1)));
        enable = ($urandom_range(0, 9) < 8);
        tick();
      end
      drain(200);
      check("rand_beat_count", beat_count, 16'(tb_beats));
      check("rand_valid_low", bus.m_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
# fifo_reader

Synthesizable read-side master for the synchronous FIFO. It drains the FIFO through its `rd_en`/`data_out`/`empty` interface and re-presents the words as a valid/ready stream to a downstream consumer. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so it sustains one word per cycle under no backpressure. It sits between the FIFO's read port and any consumer, and is the in-design counterpart of the FIFO write-side stimulus.

## Interface
- `FIFO_WIDTH`, default 16, data word width.
- `CNT_WIDTH`, default 16, width of the delivered-beat counter.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when 1, the block may issue FIFO reads.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_underflow` in 1: FIFO `underflow` flag.
- `fifo_data_out` in FIFO_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read request.
- `m_data` out FIFO_WIDTH: output word.
- `m_valid` out 1: `m_data` is valid.
- `m_ready` in 1: the consumer accepts the word. A beat is transferred when `m_valid && m_ready`.
- `busy` out 1: the state is not IDLE.
- `beat_count` out CNT_WIDTH: count of transferred beats.
- `underflow_err` out 1: sticky flag, set when `fifo_underflow` is sampled high.

## Operation
- **States**
  - IDLE: no reads issued. Moves to RUN when `enable` = 1.
  - RUN: reads are issued. Moves to FLUSH when `enable` = 0.
  - FLUSH: no new reads. Outstanding reads land and the buffer drains. Moves to IDLE when there is no read in flight and occupancy is 0. If `enable` returns to 1 while in FLUSH, move to RUN.
- **Read issue** (combinational): `fifo_rd_en` = RUN && !`fifo_empty` && (occ + inflight − pop) < 2.
  - occ is buffer occupancy (0..2).
  - inflight is `fifo_rd_en` registered.
  - pop is the transfer term `m_valid && m_ready`.
  - `m_ready` to `fifo_rd_en` is therefore a combinational path.
- **Capture**: when inflight = 1, `fifo_data_out` is written into the buffer tail on that cycle's posedge. Capture and pop may happen in the same cycle.
- **Ordering**: the buffer is FIFO-ordered. `m_data` is always the head entry. `m_valid` = (occ != 0). `m_data` stays stable while `m_valid && !m_ready`.
- **Beat counter**: `beat_count` increments by 1 per transfer and wraps modulo 2^CNT_WIDTH.
- **Underflow**: `underflow_err` is set on any posedge where `fifo_underflow` = 1. Only `rst` clears it. The block itself never asserts `fifo_rd_en` while `fifo_empty` = 1.
- **Reset**: `rst` asserted at any time, including mid-burst, forces all of the following immediately:
  - IDLE, occ = 0, inflight = 0.
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0, `beat_count` = 0, `underflow_err` = 0.
  - Any FIFO read in flight is dropped.

## Timing
- `fifo_rd_en` high in cycle t gives FIFO data in cycle t+1, captured at the end of t+1. `m_valid` is high in cycle t+2.
- First-word latency from `rd_en` is 2 cycles. Sustained throughput is 1 beat/cycle while `m_ready` = 1 and the FIFO is non-empty.
- With `m_ready` = 0: at most 2 words are buffered, and `fifo_rd_en` stays low once occ + inflight = 2. No word is lost or duplicated.
- `fifo_empty` is sampled every cycle. Back-to-back reads are legal because `empty` reflects each prior read at the next edge.
- All outputs except `fifo_rd_en` are registered.

## Structure
- `shared_pkg` gains:
  - `typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_FLUSH} rd_state_e`
  - the `FIFO_WIDTH` default constant
- Sub-module `fifo_reader_skid` holds the 2-entry buffer. Its interface is push/data_in, pop, occ, and head data. It is instantiated once.
- The FSM, issue logic, beat counter and sticky flag stay in `fifo_reader`.

## Test plan
- **Reset values**: assert `rst` mid-cycle. All outputs are 0 immediately, asynchronously. After release, state is IDLE and `busy` = 0.
- **Single word**: FIFO holds 0xA5A5, `enable` = 1, `m_ready` = 1.
  - `fifo_rd_en` pulses for 1 cycle.
  - `m_valid` rises 2 cycles later with `m_data` = 0xA5A5.
  - `beat_count` = 1.
  - The block returns to IDLE after `enable` drops.
- **Full burst**: FIFO filled with 8 words 0x0001..0x0008, `m_ready` = 1. The bench sees 8 contiguous beats in order, and `beat_count` = 8.
- **Backpressure**: same fill, `m_ready` toggled 1,0,0,1,...
  - occ never exceeds 2.
  - `m_data` is held while stalled.
  - The output sequence is exactly 0x0001..0x0008.
- **Enable drop mid-burst**: deassert `enable` after the 3rd `rd_en`.
  - FLUSH delivers the in-flight and buffered words, 3 total.
  - State returns to IDLE. The FIFO retains 5 words.
- **Reset mid-burst and underflow**:
  - `rst` during a burst clears occ and `beat_count` to 0. Restarting delivers the remaining FIFO words in order.
  - Forcing `fifo_underflow` = 1 for 1 cycle sets `underflow_err`, which stays 1 until `rst`.
